// File: rtl/mem_responder_if.sv
// Core memory bus and image-load handshake that connect a core and its loader to mem_responder.
interface mem_responder_if;
    logic [7:0] MEMAddress;
    logic [7:0] MEMdatain;
    logic       MEMwrite;
    logic [7:0] MEMdataout;
    logic       ld_start;
    logic [7:0] ld_len;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       ld_done;
    logic       core_rst_n;

    modport master (
        output MEMAddress, MEMdatain, MEMwrite, ld_start, ld_len, ld_valid, ld_data,
        input  MEMdataout, ld_ready, ld_done, core_rst_n
    );

    modport slave (
        input  MEMAddress, MEMdatain, MEMwrite, ld_start, ld_len, ld_valid, ld_data,
        output MEMdataout, ld_ready, ld_done, core_rst_n
    );
endinterface

// File: rtl/mem_responder.sv
// 256x8 memory that is first filled by an image loader, then served to a core that is
// held in reset until the image is complete.
module mem_responder #(
    parameter int RD_REG = 0
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] counter;
    logic [7:0] len;
    logic [7:0] mem [256];
    logic       load_we;
    logic       core_we;
    logic       last_byte;
    logic       ld_done_q;
    logic       core_rst_q;

    // A latched length of 0 wraps to 255 here, which is exactly the 256-byte case.
    assign last_byte = (counter == (len - 8'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_WAIT;
            counter    <= 8'd0;
            len        <= 8'd0;
            ld_done_q  <= 1'b0;
            core_rst_q <= 1'b0;
        end else begin
            state      <= next_state;
            ld_done_q  <= (state == S_LOAD) && (next_state == S_RUN);
            core_rst_q <= (next_state == S_RUN);
            if (bus.ld_start && (state != S_LOAD)) begin
                counter <= 8'd0;
                len     <= bus.ld_len;
            end else if (load_we) begin
                counter <= counter + 8'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_WAIT:  if (bus.ld_start) next_state = S_LOAD;
            S_LOAD:  if (load_we && last_byte) next_state = S_RUN;
            S_RUN:   if (bus.ld_start) next_state = S_LOAD;
            default: next_state = S_WAIT;
        endcase
    end

    always_comb begin
        bus.ld_ready   = (state == S_LOAD);
        bus.ld_done    = ld_done_q;
        bus.core_rst_n = core_rst_q;
        load_we        = (state == S_LOAD) && bus.ld_valid;
        core_we        = (state == S_RUN) && bus.MEMwrite;
    end

    // The two write sources live in disjoint states, so they never collide.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[counter] <= bus.ld_data;
        end else if (core_we) begin
            mem[bus.MEMAddress] <= bus.MEMdatain;
        end
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [7:0] rd_q;
            // Keyed on next_state so the port clears in the very cycle RUN is left.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rd_q <= 8'h00;
                end else if (next_state == S_RUN) begin
                    rd_q <= mem[bus.MEMAddress];
                end else begin
                    rd_q <= 8'h00;
                end
            end
            assign bus.MEMdataout = rd_q;
        end else begin : g_rd_comb
            assign bus.MEMdataout = (state == S_RUN) ? mem[bus.MEMAddress] : 8'h00;
        end
    endgenerate

endmodule

// File: tb/tb_mem_responder.sv
// Drives a combinational-read and a registered-read mem_responder with identical stimulus
// and compares both against a byte-count based model of loader, core bus and memory.
module tb_mem_responder;

    localparam int M_WAIT = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem_addr;
    logic [7:0] din;
    logic       wr;
    logic       ld_start;
    logic [7:0] ld_len;
    logic       ld_valid;
    logic [7:0] ld_data;

    int         compared = 0;
    int         mismatched = 0;

    int         m_mode;
    int         m_left;
    int         m_addr;
    logic       m_done;
    logic [7:0] m_rd;
    logic [7:0] m_mem [256];

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();

    assign bus0.MEMAddress = mem_addr;
    assign bus0.MEMdatain  = din;
    assign bus0.MEMwrite   = wr;
    assign bus0.ld_start   = ld_start;
    assign bus0.ld_len     = ld_len;
    assign bus0.ld_valid   = ld_valid;
    assign bus0.ld_data    = ld_data;
    assign bus1.MEMAddress = mem_addr;
    assign bus1.MEMdatain  = din;
    assign bus1.MEMwrite   = wr;
    assign bus1.ld_start   = ld_start;
    assign bus1.ld_len     = ld_len;
    assign bus1.ld_valid   = ld_valid;
    assign bus1.ld_data    = ld_data;

    mem_responder #(.RD_REG(0)) dut_comb (.clk(clk), .rst(rst), .bus(bus0));
    mem_responder #(.RD_REG(1)) dut_reg  (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Advance the model by one clock edge using the current inputs, then wait for that edge.
    task automatic cycle();
        logic [7:0] old_rd;
        old_rd = m_mem[mem_addr];
        m_done = 1'b0;
        case (m_mode)
            M_WAIT: if (ld_start) begin
                m_mode = M_LOAD;
                m_left = (ld_len == 8'd0) ? 256 : int'(ld_len);
                m_addr = 0;
            end
            M_LOAD: if (ld_valid) begin
                m_mem[m_addr] = ld_data;
                m_addr++;
                m_left--;
                if (m_left == 0) begin
                    m_mode = M_RUN;
                    m_done = 1'b1;
                end
            end
            default: begin
                if (wr) m_mem[mem_addr] = din;
                if (ld_start) begin
                    m_mode = M_LOAD;
                    m_left = (ld_len == 8'd0) ? 256 : int'(ld_len);
                    m_addr = 0;
                end
            end
        endcase
        m_rd = (m_mode == M_RUN) ? old_rd : 8'h00;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_mode = M_WAIT;
        m_left = 0;
        m_addr = 0;
        m_done = 1'b0;
        m_rd   = 8'h00;
    endtask

    function automatic logic [18:0] model_outputs();
        logic [7:0] d0;
        d0 = (m_mode == M_RUN) ? m_mem[mem_addr] : 8'h00;
        return {m_mode == M_LOAD, m_done, m_mode == M_RUN, d0, m_rd};
    endfunction

    function automatic logic [18:0] dut_outputs();
        return {bus0.ld_ready, bus0.ld_done, bus0.core_rst_n, bus0.MEMdataout, bus1.MEMdataout};
    endfunction

    task automatic test_reset();
        compared++;
        if (dut_outputs() !== 19'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_values: got %h expected %h", dut_outputs(), 19'd0);
        end
        rst = 1'b1;
        repeat (3) begin
            cycle();
            compared++;
            if (dut_outputs() !== model_outputs()) begin
                mismatched++;
                $display("[TB] FAIL idle_wait: got %h expected %h", dut_outputs(), model_outputs());
            end
        end
    endtask

    task automatic test_basic_load();
        logic [7:0] bytes [3];
        int ready_cycles = 0;
        int done_pulses = 0;
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3;
        mem_addr = 8'd0;
        ld_start = 1'b1; ld_len = 8'd3;
        cycle();
        ld_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b1; ld_data = bytes[k];
            if (bus0.ld_ready === 1'b1) ready_cycles++;
            cycle();
            if (bus0.ld_done === 1'b1) done_pulses++;
            compared++;
            if (dut_outputs() !== model_outputs()) begin
                mismatched++;
                $display("[TB] FAIL basic_load_step%0d: got %h expected %h", k, dut_outputs(), model_outputs());
            end
        end
        ld_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_addr = 8'(k);
            cycle();
            if (bus0.ld_done === 1'b1) done_pulses++;
            compared++;
            if (bus0.MEMdataout !== bytes[k] || bus0.core_rst_n !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL basic_readback%0d: got %h rstn %b expected %h rstn 1", k, bus0.MEMdataout, bus0.core_rst_n, bytes[k]);
            end
        end
        compared++;
        if (ready_cycles != 3 || done_pulses != 1) begin
            mismatched++;
            $display("[TB] FAIL basic_handshake: ready %0d done %0d expected 3 and 1", ready_cycles, done_pulses);
        end
        mem_addr = 8'd0;
    endtask

    task automatic test_gapped_load();
        logic pattern [5];
        pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b1; pattern[3] = 1'b0; pattern[4] = 1'b1;
        mem_addr = 8'd0;
        ld_start = 1'b1; ld_len = 8'd3;
        cycle();
        compared++;
        if (dut_outputs() !== model_outputs() || bus0.core_rst_n !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL gapped_start: got %h expected %h", dut_outputs(), model_outputs());
        end
        for (int k = 0; k < 5; k++) begin
            ld_valid = pattern[k];
            ld_data = 8'($urandom);
            ld_start = (k == 1);
            ld_len = 8'd7;
            cycle();
            compared++;
            if (dut_outputs() !== model_outputs()) begin
                mismatched++;
                $display("[TB] FAIL gapped_step%0d: got %h expected %h", k, dut_outputs(), model_outputs());
            end
        end
        ld_valid = 1'b0; ld_start = 1'b0;
        compared++;
        if (bus0.ld_done !== 1'b1 || bus0.core_rst_n !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL gapped_done: done %b rstn %b expected 1 1", bus0.ld_done, bus0.core_rst_n);
        end
        for (int k = 0; k < 4; k++) begin
            mem_addr = 8'(k);
            cycle();
            compared++;
            if (dut_outputs() !== model_outputs()) begin
                mismatched++;
                $display("[TB] FAIL gapped_read%0d: got %h expected %h", k, dut_outputs(), model_outputs());
            end
        end
        mem_addr = 8'd0;
    endtask

    task automatic test_full_load();
        int early_done = 0;
        mem_addr = 8'd0;
        ld_start = 1'b1; ld_len = 8'd0;
        cycle();
        ld_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ld_valid = 1'b1; ld_data = 8'(i);
            cycle();
            if (i < 255 && bus0.ld_done !== 1'b0) early_done++;
        end
        compared++;
        if (early_done != 0 || bus0.ld_done !== 1'b1 || bus0.core_rst_n !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL full_load_done: early %0d done %b rstn %b expected 0 1 1", early_done, bus0.ld_done, bus0.core_rst_n);
        end
        ld_data = 8'hEE;
        cycle();
        compared++;
        if (dut_outputs() !== model_outputs() || bus0.ld_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL full_load_extra: got %h expected %h", dut_outputs(), model_outputs());
        end
        ld_valid = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_addr = 8'(i);
            cycle();
            compared++;
            if (bus0.MEMdataout !== 8'(i) || bus1.MEMdataout !== m_rd) begin
                mismatched++;
                $display("[TB] FAIL full_read%0d: got %h/%h expected %h/%h", i, bus0.MEMdataout, bus1.MEMdataout, 8'(i), m_rd);
            end
        end
    endtask

    task automatic test_core_write();
        mem_addr = 8'h10; din = 8'h5A; wr = 1'b1;
        cycle();
        wr = 1'b0;
        compared++;
        if (bus0.MEMdataout !== 8'h5A || bus1.MEMdataout !== 8'h10) begin
            mismatched++;
            $display("[TB] FAIL write_collision: got %h/%h expected 5a/10", bus0.MEMdataout, bus1.MEMdataout);
        end
        cycle();
        compared++;
        if (bus0.MEMdataout !== 8'h5A || bus1.MEMdataout !== 8'h5A) begin
            mismatched++;
            $display("[TB] FAIL write_after: got %h/%h expected 5a/5a", bus0.MEMdataout, bus1.MEMdataout);
        end
        for (int k = 0; k < 40; k++) begin
            mem_addr = 8'h80 | 8'($urandom_range(0, 7));
            din = 8'($urandom);
            wr = 1'($urandom);
            cycle();
            compared++;
            if (dut_outputs() !== model_outputs()) begin
                mismatched++;
                $display("[TB] FAIL random_rw%0d: got %h expected %h", k, dut_outputs(), model_outputs());
            end
        end
        wr = 1'b0;
        mem_addr = 8'd0;
    endtask

    task automatic test_reload();
        logic [7:0] expect_byte;
        mem_addr = 8'h20;
        ld_start = 1'b1; ld_len = 8'd2;
        cycle();
        ld_start = 1'b0;
        compared++;
        if (bus0.core_rst_n !== 1'b0 || bus0.MEMdataout !== 8'h00 || bus1.MEMdataout !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reload_leave_run: rstn %b data %h/%h expected 0 00/00", bus0.core_rst_n, bus0.MEMdataout, bus1.MEMdataout);
        end
        for (int k = 0; k < 4; k++) begin
            mem_addr = 8'h20 + 8'(k); din = 8'hFF; wr = 1'b1;
            cycle();
        end
        wr = 1'b0; mem_addr = 8'd0;
        for (int k = 0; k < 2; k++) begin
            ld_valid = 1'b1; ld_data = 8'($urandom);
            cycle();
        end
        ld_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_addr = 8'h20 + 8'(k);
            expect_byte = 8'h20 + 8'(k);
            cycle();
            compared++;
            if (bus0.MEMdataout !== expect_byte || dut_outputs() !== model_outputs()) begin
                mismatched++;
                $display("[TB] FAIL reload_write_ignored%0d: got %h expected %h", k, bus0.MEMdataout, expect_byte);
            end
        end
        mem_addr = 8'd0;
    endtask

    task automatic test_reset_mid_load();
        mem_addr = 8'd0;
        ld_start = 1'b1; ld_len = 8'd5;
        cycle();
        ld_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ld_valid = 1'b1; ld_data = 8'($urandom);
            cycle();
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        compared++;
        if (dut_outputs() !== 19'd0) begin
            mismatched++;
            $display("[TB] FAIL async_reset: got %h expected %h", dut_outputs(), 19'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            compared++;
            if (dut_outputs() !== model_outputs()) begin
                mismatched++;
                $display("[TB] FAIL post_reset_wait%0d: got %h expected %h", k, dut_outputs(), model_outputs());
            end
        end
        ld_valid = 1'b0;
        ld_start = 1'b1; ld_len = 8'd1;
        cycle();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 8'($urandom);
        cycle();
        ld_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mem_addr = 8'(k);
            cycle();
            compared++;
            if (dut_outputs() !== model_outputs()) begin
                mismatched++;
                $display("[TB] FAIL retained%0d: got %h expected %h", k, dut_outputs(), model_outputs());
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        mem_addr = 8'd0; din = 8'd0; wr = 1'b0;
        ld_start = 1'b0; ld_len = 8'd0; ld_valid = 1'b0; ld_data = 8'd0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_basic_load();
        test_gapped_load();
        test_full_load();
        test_core_write();
        test_reload();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
